conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming 3x3 window generator. It is the producer side of the conv core's window interface.
- Accepts a raster-order pixel stream and builds the 3x3 neighbourhood with two line buffers and a 3x3 register array.
- Emits one packed 9-pixel window per fully-populated position as a single-cycle valid pulse, matching the conv core's valid_in/window_in contract.
- Valid-only convolution: no padding. Each frame yields (IMG_W-2)*(IMG_H-2) windows.

Parameters:
- DATA_W, 8, pixel width in bits (signed two's complement, passed through untouched).
- IMG_W, 8, pixels per image row (>= 3).
- IMG_H, 8, rows per frame (>= 3).
- CW, $clog2(IMG_W), column counter width (derived; not overridden).
- RW, $clog2(IMG_H), row counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  synchronous reset, active-low.
- pix_valid  in  1  pix_in/pix_sof valid this cycle; no backpressure, so every valid pixel is accepted.
- pix_sof  in  1  qualified by pix_valid; marks the first pixel (row 0, col 0) of a frame.
- pix_in  in  DATA_W  pixel data.
- win_valid  out  1  one-cycle pulse; window_out is valid.
- window_out  out  DATA_W*9  packed window.
- win_row  out  RW  row of the window's top-left pixel.
- win_col  out  CW  column of the window's top-left pixel.
- frame_done  out  1  one-cycle pulse on acceptance of the last pixel of a frame.

Behaviour:
- Reset (rstn=0 at posedge):
  - win_valid=0, frame_done=0, window_out=0, win_row=0, win_col=0.
  - Column/row counters = 0.
  - Line buffer RAM is not cleared; its contents are never exposed because output is gated by the counters.
- Accept: a pixel is accepted only when pix_valid=1.
  - Cycles with pix_valid=0 freeze all state.
  - win_valid and frame_done are 0 on those cycles; window_out and win_row/win_col hold.
- Position: effective position (r,c) of an accepted pixel = (0,0) if pix_sof=1, otherwise the counter values.
- Counters, updated after each accept:
  - c advances to c+1.
  - At c=IMG_W-1: c wraps to 0 and r advances to r+1.
  - At r=IMG_H-1, c=IMG_W-1: both wrap to 0.
- Line buffers: lb1 holds row r-1, lb2 holds row r-2, each IMG_W deep and indexed by column. On accept at column c:
  - Read a=lb2[c] and b=lb1[c].
  - Write lb2[c]<=b and lb1[c]<=pix_in.
- Window array w[row][col]:
  - On accept, shift each row left (col0<=col1, col1<=col2).
  - New column 2 = {a, b, pix_in} for rows {0,1,2}.
- Emit condition: accept at (r,c) with r>=2 and c>=2.
  - Registered output: win_valid=1 on the cycle after the accepting edge, with latency 1 from pix_valid.
  - The window content is the post-shift array.
  - win_row=r-2, win_col=c-2.
- Packing: element i = 3*row + col, with row 0 = oldest (top) and col 0 = leftmost.
  - Element i occupies window_out[DATA_W*(9-i)-1 -: DATA_W].
  - Top-left is therefore in the MSBs and the newest pixel in the LSBs.
- Column edges: windows are never emitted for c<2. Stale left columns from the previous row are flushed by the c>=2 gate.
- frame_done: registered, asserted with the same timing as win_valid for the pixel at (IMG_H-1, IMG_W-1). It coincides with the final win_valid.
- pix_sof mid-frame: the partial frame is abandoned.
  - The pixel is treated as (0,0) and no frame_done is issued for the abandoned frame.
  - Line buffer garbage is harmless because r<2 suppresses output.
- pix_sof on a pixel where the counters are already (0,0) has no extra effect.
- Reset mid-frame: the next accepted pixel is (0,0) whether or not pix_sof is asserted.
- No arithmetic is performed on pixel data; bits pass through unchanged, including sign.

Test Plan:
1. IMG_W=5, IMG_H=4; pixels 1..20 raster, sof on 1, pix_valid continuous -> exactly 6 win_valid pulses.
   - First pulse, the cycle after pixel 13 is accepted: window = 1,2,3,6,7,8,11,12,13 (MSB->LSB), win_row=0, win_col=0.
   - Last pulse, after pixel 20: 8,9,10,13,14,15,18,19,20, win_row=1, win_col=2.
   - frame_done coincides with the last pulse.
2. Same frame with pix_valid deasserted on alternate cycles -> identical window sequence and values; win_valid never on idle cycles; outputs held between pulses.
3. Two back-to-back frames (second frame pixels 101..120, sof on 101) -> second frame's first window = 101,102,103,106,107,108,111,112,113, with no window emitted from frame 1 / frame 2 mixing.
4. sof asserted at pixel 9 of frame 1, then 20 fresh pixels 201..220 -> no frame_done for the aborted frame; 6 windows, first = 201,202,203,206,207,208,211,212,213.
5. rstn low for one cycle after pixel 12 -> win_valid, frame_done, window_out, win_row and win_col all 0. A following 20-pixel stream without sof produces the 6 correct windows.
6. Signed data: pixels alternating 8'h80/8'h7F -> window_out bytes exactly equal the inputs (no sign alteration), checked against a conv core golden model downstream.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of the 3x3 window generator.
// The master side drives the raster pixel stream and consumes windows;
// the slave side (the generator) accepts pixels and produces windows.
interface conv_window_gen_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic                  pix_valid;
    logic                  pix_sof;
    logic [DATA_W-1:0]     pix_in;
    logic                  win_valid;
    logic [DATA_W*9-1:0]   window_out;
    logic [RW-1:0]         win_row;
    logic [CW-1:0]         win_col;
    logic                  frame_done;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  win_valid, window_out, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output win_valid, window_out, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator. Two column-indexed line buffers hold the
// previous two rows; a 3x3 register array slides one column per accepted
// pixel. A window is emitted once the array holds three fresh columns of
// three valid rows. Pixel bits are never interpreted, only moved.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // raster position of the next expected pixel
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // position of the pixel on the bus this cycle (sof forces origin)
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;

    // lb1 = row r-1, lb2 = row r-2; deliberately not reset
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] lb_a;
    logic [DATA_W-1:0] lb_b;

    // win_q[row][col], row 0 oldest, col 0 leftmost
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];

    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [DATA_W*9-1:0] window_out_q, window_out_d;
    logic [DATA_W*9-1:0] window_packed;
    logic [RW-1:0]       win_row_q, win_row_d;
    logic [CW-1:0]       win_col_q, win_col_d;

    logic emit;
    logic last_pix;

    // next-state: position, window shift, packing and output selection
    always_comb begin
        eff_col = bus.pix_sof ? '0 : col_q;
        eff_row = bus.pix_sof ? '0 : row_q;

        lb_a = lb2_q[eff_col];
        lb_b = lb1_q[eff_col];

        col_d = col_q;
        row_d = row_q;
        win_d = win_q;

        emit     = bus.pix_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
        last_pix = bus.pix_valid && (eff_row == RW'(IMG_H - 1))
                                 && (eff_col == CW'(IMG_W - 1));

        if (bus.pix_valid) begin
            if (eff_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_a;
            win_d[1][2] = lb_b;
            win_d[2][2] = bus.pix_in;
        end

        // top-left element lands in the MSBs, newest pixel in the LSBs
        window_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_packed[DATA_W*(9-(3*r+c))-1 -: DATA_W] = win_d[r][c];
            end
        end

        win_valid_d  = emit;
        frame_done_d = last_pix;
        window_out_d = emit ? window_packed : window_out_q;
        win_row_d    = emit ? eff_row - RW'(2) : win_row_q;
        win_col_d    = emit ? eff_col - CW'(2) : win_col_q;
    end

    // position counters, window array and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            window_out_q <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            window_out_q <= window_out_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
        end
    end

    // line buffers: push the current column down one row, store the new pixel
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb2_q[eff_col] <= lb_b;
            lb1_q[eff_col] <= bus.pix_in;
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.window_out = window_out_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x4 image.
module tb_conv_window_gen;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    typedef struct packed {
        logic [71:0] win;
        logic [1:0]  row;
        logic [2:0]  col;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic rstn;

    conv_window_gen_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();

    conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    obs_t exp_q[$];
    obs_t log_q[$];
    obs_t last_exp;
    int   done_cnt = 0;

    logic [7:0] img [H][W];
    int   pr = 0;
    int   pc = 0;
    logic exp_emit = 1'b0;

    logic acc_prev   = 1'b0;
    logic emit_prev  = 1'b0;
    logic rst_prev   = 1'b0;
    logic hold_known = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // drive one pixel; the image model supplies the expected window
    task automatic send(input logic [7:0] pix, input logic sof);
        obs_t e;
        if (sof) begin
            pr = 0;
            pc = 0;
        end
        img[pr][pc] = pix;
        exp_emit = (pr >= 2 && pc >= 2);
        if (exp_emit) begin
            e.win = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    e.win[8*(9-(3*rr+cc))-1 -: 8] = img[pr-2+rr][pc-2+cc];
            e.row  = 2'(pr - 2);
            e.col  = 3'(pc - 2);
            e.done = (pr == H-1 && pc == W-1);
            exp_q.push_back(e);
        end
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_in    = pix;
        if (pc == W-1) begin
            pc = 0;
            pr = (pr == H-1) ? 0 : pr + 1;
        end else begin
            pc++;
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        exp_emit      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        done_cnt = 0;
    endtask

    // what happened at the last active edge
    always @(posedge clk) begin
        acc_prev  <= bus.pix_valid && rstn;
        emit_prev <= exp_emit && bus.pix_valid && rstn;
        rst_prev  <= !rstn;
    end

    // monitor: compare DUT outputs against the scoreboard away from the edge
    always @(negedge clk) begin
        obs_t e;
        obs_t o;
        if (rst_prev) begin
            chk("rst_win_valid",  72'(bus.win_valid),  72'd0);
            chk("rst_frame_done", 72'(bus.frame_done), 72'd0);
            chk("rst_window_out", bus.window_out,      72'd0);
            chk("rst_win_row",    72'(bus.win_row),    72'd0);
            chk("rst_win_col",    72'(bus.win_col),    72'd0);
            last_exp   = '0;
            hold_known = 1'b1;
        end else if (emit_prev) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
            chk("win_valid_missing", 72'(bus.win_valid), 72'd1);
            if (bus.win_valid === 1'b1) begin
                chk("window_out", bus.window_out,      e.win);
                chk("win_row",    72'(bus.win_row),    72'(e.row));
                chk("win_col",    72'(bus.win_col),    72'(e.col));
                chk("frame_done", 72'(bus.frame_done), 72'(e.done));
                o.win  = bus.window_out;
                o.row  = bus.win_row;
                o.col  = bus.win_col;
                o.done = bus.frame_done;
                log_q.push_back(o);
                if (bus.frame_done === 1'b1) done_cnt++;
                last_exp   = e;
                hold_known = 1'b1;
            end
        end else begin
            chk("win_valid_spurious",  72'(bus.win_valid),  72'd0);
            chk("frame_done_spurious", 72'(bus.frame_done), 72'd0);
            if (!acc_prev && hold_known) begin
                chk("hold_window_out", bus.window_out,   last_exp.win);
                chk("hold_win_row",    72'(bus.win_row), 72'(last_exp.row));
                chk("hold_win_col",    72'(bus.win_col), 72'(last_exp.col));
            end
            if (acc_prev) hold_known = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        // 1: continuous frame
        clear_logs();
        for (int i = 1; i <= 20; i++) send(8'(i), i == 1);
        idle(3);
        chk("t1_count",     72'(log_q.size()), 72'd6);
        chk("t1_first_win", log_q.size() > 0 ? log_q[0].win : '0, 72'h010203_060708_0B0C0D);
        chk("t1_first_rc",  log_q.size() > 0 ? 72'({log_q[0].row, log_q[0].col}) : '1, 72'h00);
        chk("t1_last_win",  log_q.size() > 5 ? log_q[5].win : '0, 72'h08090A_0D0E0F_121314);
        chk("t1_last_rc",   log_q.size() > 5 ? 72'({log_q[5].row, log_q[5].col}) : '1, 72'h0A);
        chk("t1_last_done", log_q.size() > 5 ? 72'(log_q[5].done) : '0, 72'd1);
        chk("t1_done_cnt",  72'(done_cnt), 72'd1);

        // 2: same frame, valid on alternate cycles
        clear_logs();
        for (int i = 1; i <= 20; i++) begin
            send(8'(i), i == 1);
            idle(1);
        end
        idle(2);
        chk("t2_count",     72'(log_q.size()), 72'd6);
        chk("t2_first_win", log_q.size() > 0 ? log_q[0].win : '0, 72'h010203_060708_0B0C0D);
        chk("t2_last_win",  log_q.size() > 5 ? log_q[5].win : '0, 72'h08090A_0D0E0F_121314);
        chk("t2_done_cnt",  72'(done_cnt), 72'd1);

        // 3: two back-to-back frames
        clear_logs();
        for (int i = 1; i <= 20; i++) send(8'(i), i == 1);
        for (int i = 101; i <= 120; i++) send(8'(i), i == 101);
        idle(3);
        chk("t3_count",     72'(log_q.size()), 72'd12);
        chk("t3_f2_first",  log_q.size() > 6 ? log_q[6].win : '0, 72'h656667_6A6B6C_6F7071);
        chk("t3_done_cnt",  72'(done_cnt), 72'd2);

        // 4: frame aborted by sof on its ninth pixel
        clear_logs();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 1);
        for (int i = 201; i <= 220; i++) send(8'(i), i == 201);
        idle(3);
        chk("t4_count",     72'(log_q.size()), 72'd6);
        chk("t4_first_win", log_q.size() > 0 ? log_q[0].win : '0, 72'hC9CACB_CECFD0_D3D4D5);
        chk("t4_done_cnt",  72'(done_cnt), 72'd1);

        // 5: reset after pixel 12, then a frame without sof
        clear_logs();
        for (int i = 1; i <= 12; i++) send(8'(i), i == 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        pr = 0;
        pc = 0;
        idle(1);
        for (int i = 1; i <= 20; i++) send(8'(i), 1'b0);
        idle(3);
        chk("t5_count",     72'(log_q.size()), 72'd6);
        chk("t5_first_win", log_q.size() > 0 ? log_q[0].win : '0, 72'h010203_060708_0B0C0D);
        chk("t5_last_win",  log_q.size() > 5 ? log_q[5].win : '0, 72'h08090A_0D0E0F_121314);
        chk("t5_done_cnt",  72'(done_cnt), 72'd1);

        // 6: signed extremes pass through untouched
        clear_logs();
        for (int i = 1; i <= 20; i++) send((i % 2) ? 8'h80 : 8'h7F, i == 1);
        idle(3);
        chk("t6_count",     72'(log_q.size()), 72'd6);
        chk("t6_first_win", log_q.size() > 0 ? log_q[0].win : '0, 72'h807F80_7F807F_807F80);
        chk("t6_last_win",  log_q.size() > 5 ? log_q[5].win : '0, 72'h7F807F_807F80_7F807F);

        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
